pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit; successor to the combinational PC+1 incrementer.
//  Holds the PC register and selects the next PC each cycle: sequential step, stall hold,
//  branch redirect or jump redirect. Emits a one-cycle flush pulse to the IF/ID register.
//  Sits at the head of the fetch stage, feeding the instruction memory address.
// PARAMETERS
//  WIDTH      32  PC width in bits; all PC arithmetic is modulo 2**WIDTH
//  STEP       1   increment per sequential fetch (word-addressed memory)
//  RESET_PC   0   PC value loaded on reset
//  RAS_DEPTH  4   return-address-stack entries; only used with PC_SEQ_RAS_EN; power of 2, >=2
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      asynchronous, active-high reset
//  stall          in   1      hold PC (hazard unit)
//  br_taken       in   1      branch resolved taken this cycle
//  br_target      in   WIDTH  branch target address
//  jmp            in   1      unconditional jump
//  jmp_target     in   WIDTH  jump target address
//  call           in   1      jump is a call (RAS push); qualified by jmp
//  ret            in   1      return (RAS pop); takes effect only with PC_SEQ_RAS_EN
//  pc             out  WIDTH  current fetch PC (registered)
//  pc_plus        out  WIDTH  pc + STEP (combinational, wraps)
//  flush          out  1      registered; high the cycle after any redirect
//  ras_err        out  1      sticky; push on full or pop on empty (0 when RAS compiled out)
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, flush=0, ras_err=0, RAS count=0.
//  Next-PC priority per rising edge, highest first:
//   1 br_taken          -> br_target
//   2 jmp               -> jmp_target (call also pushes pc_plus when RAS enabled)
//   3 ret (RAS_EN only) -> popped RAS top; if empty: pc_plus, set ras_err
//   4 stall             -> hold pc
//   5 otherwise         -> pc_plus
//  Redirects (1-3) override stall. flush <= 1 for exactly one cycle after any of 1-3, else 0.
//  br_taken with jmp at the same time: branch wins, jmp/call ignored, no push.
//  Wrap: pc = 2**WIDTH-STEP steps to 0; no error flag.
//  Latency: a redirect presented in cycle N is visible on pc in cycle N+1.
//  Targets are used unmodified (no alignment check).
//  Reset mid-operation: PC, flush and RAS cleared immediately, independent of clk.
// CONFIGURATION
//  PC_SEQ_RAS_EN defined: RAS_DEPTH-entry LIFO, count 0..RAS_DEPTH.
//   - push on jmp&call: store pc_plus
//   - push when full: overwrite the oldest entry (circular), set ras_err
//   - pop on ret: take the top entry
//   - pop when empty: fall through to pc_plus, set ras_err
//   - call&ret together with jmp: jmp/push wins, ret ignored
//  PC_SEQ_RAS_EN undefined: ret ignored; call is a plain jump; ras_err tied 0;
//   no RAS storage synthesised.
// STRUCTURE
//  pc_pkg: constants PC_WIDTH_DEF=32, PC_STEP_DEF=1;
//   typedef enum pc_sel_t {SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JMP, SEL_RET};
//   shared with the hazard unit and fetch stage.
//  Sub-module pc_ras (RAS_DEPTH, WIDTH): LIFO with push/pop/full/empty,
//   instantiated only under PC_SEQ_RAS_EN.
//  Top: priority select (pc_sel_t), PC register, flush flop.
// TESTING
//  T1 reset: rst=1 mid-cycle, RESET_PC=0x100 -> pc=0x100 at once; flush=0; 4 free cycles -> pc=0x104
//  T2 stall: 3 cycles stall=1 at pc=0x10 -> pc stays 0x10, flush=0; release -> 0x11
//  T3 priority: stall=1, br_taken=1 to 0x40, jmp=1 to 0x80 in one cycle -> pc=0x40; flush=1 for one cycle
//  T4 wrap: WIDTH=8, pc=0xFF, no control -> pc=0x00; pc_plus=0x01
//  T5 RAS (EN, DEPTH=4):
//   - call from 0x20 to 0x50 -> pc=0x50
//   - ret -> pc=0x21; flush each redirect
//  T6 RAS errors (EN, DEPTH=4):
//   - 5 nested calls -> ras_err=1; 4 rets return to the 4 newest addresses
//   - 5th ret -> pc=pc_plus
//   - compiled out: ret ignored, ras_err=0

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter unit. The hazard unit and the
// fetch stage import this package as well, so the next-PC select encoding
// lives here rather than inside the sequencer.
//   PC_WIDTH_DEF : default PC width in bits
//   PC_STEP_DEF  : default sequential increment (word-addressed memory)
//   pc_sel_t     : next-PC source chosen each cycle
//   isRedirect() : true for the selects that discard the fetched instruction
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

  localparam int PC_WIDTH_DEF = 32;
  localparam int PC_STEP_DEF  = 1;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BR,
    SEL_JMP,
    SEL_RET
  } pc_sel_t;

  // Branch, jump and return all redirect fetch, so the instruction already in
  // IF/ID belongs to the wrong path and has to be flushed.
  function automatic logic isRedirect(input pc_sel_t sel);
    return (sel == SEL_BR) || (sel == SEL_JMP) || (sel == SEL_RET);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Control and result bundle between the pipeline control logic (master) and
// the program-counter sequencer (slave).
//   stall      : hold PC (hazard unit)
//   br_taken   : branch resolved taken, target in br_target
//   jmp        : unconditional jump, target in jmp_target
//   call       : jump is a call (pushes return address when the RAS exists)
//   ret        : return (pops the RAS when the RAS exists)
//   pc         : current fetch PC (registered)
//   pc_plus    : pc + STEP (combinational, wraps)
//   flush      : one-cycle IF/ID flush after any redirect
//   ras_err    : sticky return-address-stack overflow/underflow flag
// -----------------------------------------------------------------------------
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF
);

  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jmp;
  logic [WIDTH-1:0] jmp_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             flush;
  logic             ras_err;

  modport master (
    output stall, br_taken, br_target, jmp, jmp_target, call, ret,
    input  pc, pc_plus, flush, ras_err
  );

  modport slave (
    input  stall, br_taken, br_target, jmp, jmp_target, call, ret,
    output pc, pc_plus, flush, ras_err
  );

endinterface

// File: rtl/pc_sequencer_ras.sv
// -----------------------------------------------------------------------------
// pc_sequencer_ras
// Return-address stack: DEPTH-entry LIFO held in a circular buffer. A push
// when full overwrites the oldest entry, so the newest DEPTH return addresses
// always survive deep call chains. Overflow and underflow set a sticky error.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : store i_pushData on top
//   i_pop        : remove top entry (ignored except for the error when empty)
//   i_pushData   : return address to store
//   o_top        : current top entry (valid when !o_empty)
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
//   o_err        : sticky, push-on-full or pop-on-empty seen since reset
// DEPTH must be a power of two and at least 2 so the pointer wraps naturally.
// -----------------------------------------------------------------------------
module pc_sequencer_ras
  import pc_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_pushData,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic [PTR_W-1:0] w_topPtr;

  // r_wrPtr is the next free slot; the top sits one below it. When the
  // buffer is full r_wrPtr lands on the oldest entry, which is exactly the
  // slot an overflowing push must overwrite.
  assign w_topPtr = r_wrPtr - PTR_W'(1);
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_top    = r_mem[w_topPtr];
  assign o_err    = r_err;

  // Stack storage, pointer and occupancy. Push and pop are never requested
  // together by the sequencer; push is given precedence regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (i_push) begin
      r_mem[r_wrPtr] <= i_pushData;
      r_wrPtr        <= r_wrPtr + PTR_W'(1);
      if (o_full) begin
        r_err <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop) begin
      if (o_empty) begin
        r_err <= 1'b1;
      end else begin
        r_wrPtr <= w_topPtr;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter unit at the head of the fetch stage. Holds the PC and picks
// the next PC each cycle (branch > jump > return > stall > sequential step),
// and raises a one-cycle flush toward IF/ID after every redirect.
// Parameters:
//   WIDTH     : PC width; all PC arithmetic wraps modulo 2**WIDTH
//   STEP      : sequential increment
//   RESET_PC  : PC loaded on reset
//   RAS_DEPTH : return-address-stack depth (power of two, >= 2)
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : pc_sequencer_if.slave (controls in; pc, pc_plus, flush,
//               ras_err out)
// Build option:
//   PC_SEQ_RAS_EN : when defined, a pc_sequencer_ras return-address stack is
//                   built; call pushes pc_plus and ret pops. When undefined,
//                   ret is ignored, call is a plain jump and ras_err is 0.
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned      STEP      = PC_STEP_DEF,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);

  logic [WIDTH-1:0] r_pc;
  logic             r_flush;
  logic [WIDTH-1:0] w_pcPlus;
  logic [WIDTH-1:0] w_pcNext;
  pc_sel_t          w_sel;
  logic             w_retValid;
  logic [WIDTH-1:0] w_rasTop;
  logic             w_rasEmpty;
  logic             w_rasErr;

  assign w_pcPlus = r_pc + WIDTH'(STEP);

`ifdef PC_SEQ_RAS_EN
  logic w_push;
  logic w_pop;
  logic w_unusedRasFull;

  // Push only on a jump that actually wins arbitration, so a call that loses
  // to a taken branch leaves the stack untouched.
  assign w_retValid = bus.ret;
  assign w_push     = (w_sel == SEL_JMP) && bus.call;
  assign w_pop      = (w_sel == SEL_RET);

  pc_sequencer_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) uRas (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_pushData (w_pcPlus),
    .o_top      (w_rasTop),
    .o_full     (w_unusedRasFull),
    .o_empty    (w_rasEmpty),
    .o_err      (w_rasErr)
  );
`else
  logic [2:0] w_unusedCtl;

  // Without a stack, ret never redirects and call behaves as a plain jump.
  assign w_retValid  = 1'b0;
  assign w_rasTop    = '0;
  assign w_rasEmpty  = 1'b1;
  assign w_rasErr    = 1'b0;
  assign w_unusedCtl = {bus.call, bus.ret, RAS_DEPTH[0]};
`endif

  // Priority select. Every redirect beats stall: the stalled instruction is
  // on the wrong path anyway once a redirect resolves.
  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.br_taken) begin
      w_sel = SEL_BR;
    end else if (bus.jmp) begin
      w_sel = SEL_JMP;
    end else if (w_retValid) begin
      w_sel = SEL_RET;
    end else if (bus.stall) begin
      w_sel = SEL_HOLD;
    end
  end

  // Next-PC mux. A return with an empty stack still counts as a redirect but
  // falls through to the sequential address.
  always_comb begin
    w_pcNext = w_pcPlus;
    case (w_sel)
      SEL_BR:   w_pcNext = bus.br_target;
      SEL_JMP:  w_pcNext = bus.jmp_target;
      SEL_RET:  w_pcNext = w_rasEmpty ? w_pcPlus : w_rasTop;
      SEL_HOLD: w_pcNext = r_pc;
      default:  w_pcNext = w_pcPlus;
    endcase
  end

  // PC register and flush flop; flush is high exactly the cycle after a
  // redirect, lining up with the wrong-path instruction sitting in IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
    end else begin
      r_pc    <= w_pcNext;
      r_flush <= isRedirect(w_sel);
    end
  end

  assign bus.pc      = r_pc;
  assign bus.pc_plus = w_pcPlus;
  assign bus.flush   = r_flush;
  assign bus.ras_err = w_rasErr;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Drives two sequencers with identical controls: a 32-bit one resetting to
// 0x100 and an 8-bit one resetting to 0xFC (to reach the wrap quickly). A
// reference model of the next-PC rules, kept per instance, is compared with
// both on every falling edge; directed steps add hand-computed literal checks.
// Honors PC_SEQ_RAS_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic        inStall;
  logic        inBr;
  logic [31:0] inBrT;
  logic        inJmp;
  logic [31:0] inJT;
  logic        inCall;
  logic        inRet;

  pc_sequencer_if #(.WIDTH(32)) busA ();
  pc_sequencer_if #(.WIDTH(8))  busB ();

  assign busA.stall      = inStall;
  assign busA.br_taken   = inBr;
  assign busA.br_target  = inBrT;
  assign busA.jmp        = inJmp;
  assign busA.jmp_target = inJT;
  assign busA.call       = inCall;
  assign busA.ret        = inRet;

  assign busB.stall      = inStall;
  assign busB.br_taken   = inBr;
  assign busB.br_target  = inBrT[7:0];
  assign busB.jmp        = inJmp;
  assign busB.jmp_target = inJT[7:0];
  assign busB.call       = inCall;
  assign busB.ret        = inRet;

  pc_sequencer #(
    .WIDTH     (32),
    .STEP      (1),
    .RESET_PC  (32'h100),
    .RAS_DEPTH (4)
  ) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  pc_sequencer #(
    .WIDTH     (8),
    .STEP      (1),
    .RESET_PC  (8'hFC),
    .RAS_DEPTH (4)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  localparam logic [31:0] MASK   [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  localparam logic [31:0] RST_PC [2] = '{32'h0000_0100, 32'h0000_00FC};

  // Model state: ras[0] is the oldest entry, ras[cnt-1] the newest.
  typedef struct packed {
    logic [31:0]       pc;
    logic              flush;
    logic              err;
    logic [2:0]        cnt;
    logic [3:0][31:0]  ras;
  } model_t;

  model_t m [2];

  int  checks    = 0;
  int  errors    = 0;
  bit  compareOn = 1'b0;

  // Next state straight from the priority rules: branch, jump (+push),
  // return (pop or fall-through with error), stall, sequential.
  function automatic model_t modelNext(input model_t s, input int d);
    model_t      n;
    logic [31:0] plus;
    n     = s;
    plus  = (s.pc + 32'd1) & MASK[d];
    n.flush = 1'b1;
    if (inBr) begin
      n.pc = inBrT & MASK[d];
    end else if (inJmp) begin
      if (RAS_ON && inCall) begin
        if (s.cnt == 3'd4) begin
          n.ras = {plus, s.ras[3], s.ras[2], s.ras[1]};
          n.err = 1'b1;
        end else begin
          n.ras[s.cnt[1:0]] = plus;
          n.cnt = s.cnt + 3'd1;
        end
      end
      n.pc = inJT & MASK[d];
    end else if (RAS_ON && inRet) begin
      if (s.cnt == 3'd0) begin
        n.pc  = plus;
        n.err = 1'b1;
      end else begin
        n.cnt = s.cnt - 3'd1;
        n.pc  = s.ras[n.cnt[1:0]];
      end
    end else begin
      n.flush = 1'b0;
      n.pc    = inStall ? s.pc : plus;
    end
    return n;
  endfunction

  function automatic model_t modelReset(input int d);
    model_t r;
    r    = '0;
    r.pc = RST_PC[d];
    return r;
  endfunction

  // Model advance, mirroring the asynchronous reset of the hardware.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m[0] <= modelReset(0);
      m[1] <= modelReset(1);
    end else begin
      m[0] <= modelNext(m[0], 0);
      m[1] <= modelNext(m[1], 1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("A.pc",      busA.pc,                 m[0].pc);
      checkOutput("A.pc_plus", busA.pc_plus,            (m[0].pc + 32'd1) & MASK[0]);
      checkOutput("A.flush",   {31'd0, busA.flush},     {31'd0, m[0].flush});
      checkOutput("A.ras_err", {31'd0, busA.ras_err},   {31'd0, m[0].err});
      checkOutput("B.pc",      {24'd0, busB.pc},        m[1].pc);
      checkOutput("B.pc_plus", {24'd0, busB.pc_plus},   (m[1].pc + 32'd1) & MASK[1]);
      checkOutput("B.flush",   {31'd0, busB.flush},     {31'd0, m[1].flush});
      checkOutput("B.ras_err", {31'd0, busB.ras_err},   {31'd0, m[1].err});
    end
  end

  task automatic driveInputs(input logic st, input logic br, input logic [31:0] brT,
                             input logic jp, input logic [31:0] jT,
                             input logic cl, input logic rt);
    inStall = st;
    inBr    = br;
    inBrT   = brT;
    inJmp   = jp;
    inJT    = jT;
    inCall  = cl;
    inRet   = rt;
  endtask

  // Present one cycle of controls; returns just after the capturing edge.
  task automatic applyStimulus(input logic st, input logic br, input logic [31:0] brT,
                               input logic jp, input logic [31:0] jT,
                               input logic cl, input logic rt);
    driveInputs(st, br, brT, jp, jT, cl, rt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic jumpTo(input logic [31:0] t, input logic cl);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, t, cl, 1'b0);
  endtask

  initial begin
    driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    compareOn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset A.pc",      busA.pc,             32'h100);
    checkOutput("reset B.pc",      {24'd0, busB.pc},    32'hFC);
    checkOutput("reset A.flush",   {31'd0, busA.flush}, 32'd0);
    checkOutput("reset A.ras_err", {31'd0, busA.ras_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: four free cycles after reset; B also wraps 0xFC -> 0x00
    repeat (4) idle();
    checkOutput("T1 A.pc after 4",   busA.pc,               32'h104);
    checkOutput("T1 B.pc wrap",      {24'd0, busB.pc},      32'h00);
    checkOutput("T1 B.pc_plus wrap", {24'd0, busB.pc_plus}, 32'h01);

    // Mid-cycle reset while flush is high clears PC and flush at once
    jumpTo(32'h200, 1'b0);
    checkOutput("jump A.pc",    busA.pc,             32'h200);
    checkOutput("jump A.flush", {31'd0, busA.flush}, 32'd1);
    driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst A.pc",    busA.pc,             32'h100);
    checkOutput("async rst A.flush", {31'd0, busA.flush}, 32'd0);
    checkOutput("async rst B.pc",    {24'd0, busB.pc},    32'hFC);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) idle();
    checkOutput("T1 A.pc after rst", busA.pc, 32'h104);

    // T2: stall holds for three cycles, release steps
    jumpTo(32'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("T2 stall A.pc",    busA.pc,             32'h10);
      checkOutput("T2 stall A.flush", {31'd0, busA.flush}, 32'd0);
    end
    idle();
    checkOutput("T2 release A.pc", busA.pc, 32'h11);

    // T3: branch beats jump (with call) and stall
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 1'b0);
    checkOutput("T3 A.pc",    busA.pc,             32'h40);
    checkOutput("T3 A.flush", {31'd0, busA.flush}, 32'd1);
    idle();
    checkOutput("T3 next A.pc",    busA.pc,             32'h41);
    checkOutput("T3 next A.flush", {31'd0, busA.flush}, 32'd0);

    // T4: 8-bit PC wraps from 0xFF
    jumpTo(32'hFF, 1'b0);
    checkOutput("T4 B.pc",  {24'd0, busB.pc}, 32'hFF);
    idle();
    checkOutput("T4 B.pc wrap",      {24'd0, busB.pc},      32'h00);
    checkOutput("T4 B.pc_plus wrap", {24'd0, busB.pc_plus}, 32'h01);
    checkOutput("T4 A.pc",           busA.pc,               32'h100);

`ifdef PC_SEQ_RAS_EN
    // T5: call then return
    jumpTo(32'h20, 1'b0);
    jumpTo(32'h50, 1'b1);
    checkOutput("T5 call A.pc",    busA.pc,             32'h50);
    checkOutput("T5 call A.flush", {31'd0, busA.flush}, 32'd1);
    idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("T5 ret A.pc",      busA.pc,               32'h21);
    checkOutput("T5 ret A.flush",   {31'd0, busA.flush},   32'd1);
    checkOutput("T5 A.ras_err",     {31'd0, busA.ras_err}, 32'd0);

    // T6: five nested calls overflow; first one also carries ret (ignored)
    jumpTo(32'h100, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b1);
    for (int k = 3; k <= 6; k++) begin
      jumpTo(32'(k) << 8, 1'b1);
    end
    checkOutput("T6 calls A.pc",     busA.pc,               32'h600);
    checkOutput("T6 overflow err",   {31'd0, busA.ras_err}, 32'd1);
    for (int k = 5; k >= 2; k--) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("T6 ret A.pc", busA.pc, (32'(k) << 8) + 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("T6 empty ret A.pc",    busA.pc,               32'h202);
    checkOutput("T6 empty ret A.flush", {31'd0, busA.flush},   32'd1);
    checkOutput("T6 empty ret err",     {31'd0, busA.ras_err}, 32'd1);

    // Reset clears the sticky error and the stack
    driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst clears ras_err", {31'd0, busA.ras_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("ret after rst A.pc", busA.pc,               32'h101);
    checkOutput("ret after rst err",  {31'd0, busA.ras_err}, 32'd1);
`else
    // Stack compiled out: ret is ignored, call is a plain jump
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("no-RAS ret A.pc",    busA.pc,             32'h101);
    checkOutput("no-RAS ret A.flush", {31'd0, busA.flush}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("no-RAS ret+stall A.pc", busA.pc, 32'h101);
    jumpTo(32'h30, 1'b1);
    checkOutput("no-RAS call A.pc", busA.pc, 32'h30);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("no-RAS ret2 A.pc",   busA.pc,               32'h31);
    checkOutput("no-RAS A.ras_err",   {31'd0, busA.ras_err}, 32'd0);
`endif

    repeat (2) idle();
    @(negedge clk);
    compareOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
